// File: rtl/scheduling_unit.sv
// SHA-256 message-schedule generator: 16 x 32-bit circular buffer producing W[0..63].
// Optional SCHEDULING_UNIT_REG_OUT_EN registers schedule_out (one cycle of latency).
module scheduling_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [5:0]   index,
    input  logic [511:0] data_in,
    output logic [31:0]  schedule_out
);

    logic [31:0] r_slot [16];

    logic [3:0]  w_rd_idx;
    logic [3:0]  w_wr_idx;
    logic [3:0]  w_m1_idx;
    logic [3:0]  w_m6_idx;
    logic [3:0]  w_m14_idx;
    logic [3:0]  w_m15_idx;
    logic        w_gen_en;
    logic [31:0] w_next;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Slot offsets wrap in 4 bits; W[index-15] shares the slot being overwritten.
    always_comb begin
        w_rd_idx  = index[3:0];
        w_wr_idx  = index[3:0] + 4'd1;
        w_m1_idx  = index[3:0] - 4'd1;
        w_m6_idx  = index[3:0] - 4'd6;
        w_m14_idx = index[3:0] + 4'd2;
        w_m15_idx = index[3:0] + 4'd1;
        w_gen_en  = (index >= 6'd15) && (index <= 6'd62);
        w_next    = sigma1(r_slot[w_m1_idx]) + r_slot[w_m6_idx]
                  + sigma0(r_slot[w_m14_idx]) + r_slot[w_m15_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_slot[i] <= '0;
            end
        end else if (init) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_slot[i] <= data_in[511 - 32*i -: 32];
            end
        end else if (w_gen_en) begin
            r_slot[w_wr_idx] <= w_next;
        end
    end

`ifdef SCHEDULING_UNIT_REG_OUT_EN
    logic [31:0] r_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= r_slot[w_rd_idx];
        end
    end

    assign schedule_out = r_out;
`else
    assign schedule_out = r_slot[w_rd_idx];
`endif

endmodule

// File: tb/tb_scheduling_unit.sv
// Self-checking bench for scheduling_unit: vector table plus multi-cycle sequences,
// compared through a latency-aware scoreboard against a linear SHA-256 schedule model.
module tb_scheduling_unit;

`ifdef SCHEDULING_UNIT_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    localparam logic [511:0] HELLO = {32'h68656c6c, 32'h6f800000, 416'h0, 32'h00000028};

    logic         clk;
    logic         reset;
    logic         init;
    logic [5:0]   index;
    logic [511:0] data_in;
    logic [31:0]  schedule_out;

    scheduling_unit dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .index        (index),
        .data_in      (data_in),
        .schedule_out (schedule_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ini;
        logic [5:0]  idx;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        logic [7:0]  scn;
        logic [5:0]  idx;
    } sb_t;

    sb_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mw [64];
    vec_t        tbl [35];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] d);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) mw[t] = d[511 - 32*t -: 32];
            else        mw[t] = ms1(mw[t-2]) + mw[t-7] + ms0(mw[t-15]) + mw[t-16];
        end
    endtask

    // One clock: drive after the edge, push the expected slot value, compare at mid-cycle.
    task automatic cyc(input logic rst, input logic ini, input logic [5:0] idx,
                       input logic [511:0] d, input logic chk, input logic [31:0] exp,
                       input logic [7:0] scn);
        sb_t e;
        @(posedge clk);
        #1;
        reset   = rst;
        init    = ini;
        index   = idx;
        data_in = d;
        sb.push_back('{chk: chk, exp: exp, scn: scn, idx: idx});
        @(negedge clk);
        if (sb.size() > LAT) begin
            e = sb.pop_front();
            if (e.chk) begin
                total++;
                if (schedule_out !== e.exp) begin
                    bad++;
                    $display("FAIL sched scn=%0d idx=%0d got=%h exp=%h",
                             e.scn, e.idx, schedule_out, e.exp);
                end
            end
        end
    endtask

    // Init cycle at index 0, then index 1..last checked against the model.
    task automatic run_block(input logic [511:0] d, input int last, input logic [7:0] scn);
        logic [31:0] ex;
        build_model(d);
        cyc(1'b0, 1'b1, 6'd0, d, 1'b0, '0, scn);
        for (int t = 1; t <= last; t++) begin
            ex = mw[t];
            if (d == HELLO && t == 16) ex = 32'h7594884C;
            if (d == HELLO && t == 17) ex = 32'h6F910000;
            cyc(1'b0, 1'b0, 6'(t), d, 1'b1, ex, scn);
        end
    endtask

    initial begin
        logic [511:0] blk_b;

        reset   = 1'b1;
        init    = 1'b0;
        index   = '0;
        data_in = '0;

        // Table: reset, reads of a cleared buffer, hello load, held reads of W0..W15.
        build_model(HELLO);
        for (int i = 0; i < 2; i++)  tbl[i]      = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0};
        for (int i = 0; i < 16; i++) tbl[2 + i]  = '{1'b0, 1'b0, 6'(i), 1'b1, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 6'd0, 1'b0, 32'h0};
        for (int i = 0; i < 16; i++) tbl[19 + i] = '{1'b0, 1'b0, 6'(i), 1'b1, mw[i]};
        tbl[19]      .exp = 32'h68656c6c;
        tbl[20]      .exp = 32'h6f800000;
        tbl[34]      .exp = 32'h00000028;
        for (int i = 0; i < 35; i++) begin
            cyc(tbl[i].rst, tbl[i].ini, tbl[i].idx, HELLO, tbl[i].chk, tbl[i].exp, 8'd1);
        end

        // Full hello run to index 63.
        run_block(HELLO, 63, 8'd2);

        // Reset at index 30, cleared output afterwards, then identical re-init run.
        run_block(HELLO, 29, 8'd3);
        cyc(1'b1, 1'b0, 6'd30, HELLO, 1'b0, '0, 8'd3);
        cyc(1'b0, 1'b0, 6'd31, HELLO, 1'b1, 32'h0, 8'd3);
        cyc(1'b0, 1'b0, 6'd32, HELLO, 1'b1, 32'h0, 8'd3);
        run_block(HELLO, 63, 8'd4);

        // Random block interrupted at index 40 by an init of hello.
        for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = $urandom;
        run_block(blk_b, 40, 8'd5);
        run_block(HELLO, 63, 8'd6);

        // Drain the scoreboard for the registered-output build.
        cyc(1'b0, 1'b0, 6'd63, HELLO, 1'b0, '0, 8'd7);
        cyc(1'b0, 1'b0, 6'd63, HELLO, 1'b0, '0, 8'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scheduling_unit.md
SCHEDULING_UNIT -- requirements
Module: scheduling_unit

Interface
REQ-001 SHALL use clock clk and reset reset; reset is synchronous and active-high.
REQ-002 SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- init  input  1  load a new 512-bit block
- index  input  6  message-schedule word number t (0..63)
- data_in  input  512  padded message block; W0 = data_in[511:480], W15 = data_in[31:0]
- schedule_out  output  32  SHA-256 schedule word W[index]

Function
REQ-003 SHALL hold a 16-entry x 32-bit circular buffer; slot k holds the most recent W[t] with t mod 16 = k.
REQ-004 On a rising edge with init=1 (reset=0), slot i SHALL load data_in[511-32i -: 32] for i=0..15.
REQ-005 On a rising edge with init=0, reset=0 and 15 <= index <= 62, slot (index+1) mod 16 SHALL be written with W[index+1] = s1(W[index-1]) + W[index-6] + s0(W[index-14]) + W[index-15].
- All W operands are read from the slots before the write.
- The sum is modulo 2^32.
REQ-006 s0(x) SHALL equal ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-007 s1(x) SHALL equal ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-008 With init=0 and index < 15 or index = 63, the buffer SHALL hold its contents.
REQ-009 schedule_out SHALL be combinational, equal to slot[index mod 16], with zero latency (default build).
REQ-010 The caller SHALL advance index by exactly 1 per clock after init: index 0 in the init cycle, 1 in the next, and so on to 63.
- Skipped or repeated index values give undefined words for t >= 16.
- Such misuse SHALL NOT lock up the block; the next init recovers it.
REQ-011 Simultaneous reset and init: reset SHALL win.
REQ-012 init asserted mid-sequence SHALL reload the buffer from data_in, overriding any generate write in that edge.
REQ-013 The computation SHALL be a single-cycle datapath: 4 operands, two sigma functions, three 32-bit adders; no multicycle paths.

Reset
REQ-014 On a reset edge, all 16 slots SHALL clear to 0; schedule_out then reads 0x00000000 for every index.
REQ-015 Reset SHALL be honoured in any cycle, including mid-sequence; init is required again afterwards.

Configuration
REQ-016 Macro SCHEDULING_UNIT_REG_OUT_EN:
- When defined, schedule_out SHALL be registered. It equals slot[index mod 16] as sampled at the previous rising edge, giving one cycle of latency. The register is reset to 0.
- When undefined, the output SHALL be combinational per REQ-009.
- Buffer update rules are identical in both builds.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset for 2 cycles, init=0 -> schedule_out = 0x00000000 for index 0..15.
- Load block "hello" (data_in = 0x68656c6c_6f800000_00..00_00000028) with init=1, index=0 -> index 0 reads 0x68656c6c; index 1 reads 0x6f800000; index 2..14 read 0; index 15 reads 0x00000028.
- Continue with index incrementing each clock -> W16 = 0x7594884C and W17 = 0x6F910000.
- Full run to index 63 -> every W[t] matches a software SHA-256 message-schedule model.
- Assert reset at index 30 -> output 0 next cycle; re-init with the same block -> identical W0..W63 sequence.
- Build with SCHEDULING_UNIT_REG_OUT_EN -> same values, each one clock later.
